fifo_read_mux: RTL and testbench

Round-robin read multiplexer that merges the per-receiver FE FIFOs and the TLU FIFO into the single 32-bit word stream consumed by the SRAM output FIFO. It sits between the N first-word-fall-through source FIFOs (fei4_rx instances, tlu_controller) and out_fifo. It replaces the combinational arbiter/AND-OR mux with a registered grant, a one-word output register and fair rotation. Every word is forwarded exactly once and source order is preserved.

---
 rtl/fifo_read_mux.sv | 128 ++++++++++++
 tb/tb_fifo_read_mux.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_mux.sv
// Round-robin read multiplexer merging N first-word-fall-through source FIFOs into one registered word stream.
// Define FIFO_READ_MUX_BURST_EN to hold a grant for up to MAX_BURST words; otherwise the grant rotates every word.
module fifo_read_mux #(
    parameter int unsigned N_SRC     = 5,
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    input  logic [N_SRC-1:0]       SRC_EMPTY,
    input  logic [N_SRC*DSIZE-1:0] SRC_DATA,
    output logic [N_SRC-1:0]       SRC_READ,
    input  logic                   FIFO_READ_NEXT,
    output logic                   FIFO_EMPTY,
    output logic [DSIZE-1:0]       FIFO_DATA,
    output logic [N_SRC-1:0]       GRANT,
    output logic                   READ_ERROR
);

    localparam int unsigned IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("MAX_BURST must be within 1..255");
    end

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t         state;
    logic [IW-1:0]  last_idx;
    logic [IW-1:0]  grant_idx;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  cand_idx;
    logic           pick_found;
    logic           out_valid;
    logic           load;
    logic           src_avail;
    logic           src_read_any;
    logic           burst_done;
    logic [DSIZE-1:0] sel_word;

    assign load         = ~out_valid | FIFO_READ_NEXT;
    assign src_avail    = |(GRANT & ~SRC_EMPTY);
    assign src_read_any = (state == GRANTED) && load && src_avail;
    assign SRC_READ     = src_read_any ? (GRANT & ~SRC_EMPTY) : '0;
    assign FIFO_EMPTY   = ~out_valid;

    // Cyclic search starting one past the last served source
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            cand_idx = IW'((32'(last_idx) + k) % N_SRC);
            if (!pick_found && !SRC_EMPTY[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (GRANT[i]) sel_word = SRC_DATA[i*DSIZE +: DSIZE];
        end
    end

`ifdef FIFO_READ_MUX_BURST_EN
    logic [7:0] burst_cnt;

    assign burst_done = (burst_cnt == 8'(MAX_BURST - 1));

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST)
            burst_cnt <= '0;
        else if (state == IDLE)
            burst_cnt <= '0;
        else if (src_read_any)
            burst_cnt <= burst_cnt + 8'd1;
    end
`else
    assign burst_done = 1'b1;
`endif

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state      <= IDLE;
            GRANT      <= '0;
            grant_idx  <= '0;
            last_idx   <= IW'(N_SRC - 1);
            out_valid  <= 1'b0;
            FIFO_DATA  <= '0;
            READ_ERROR <= 1'b0;
        end else begin
            READ_ERROR <= FIFO_READ_NEXT & ~out_valid;

            // A load in the same cycle as a pop keeps the register full
            if (src_read_any) begin
                FIFO_DATA <= sel_word;
                out_valid <= 1'b1;
            end else if (FIFO_READ_NEXT) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANTED;
                        grant_idx <= pick_idx;
                        GRANT     <= N_SRC'(1) << pick_idx;
                    end
                end
                GRANTED: begin
                    if ((load && !src_avail) || (src_read_any && burst_done)) begin
                        state    <= IDLE;
                        GRANT    <= '0;
                        last_idx <= grant_idx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_mux.sv
// Bench for fifo_read_mux: queue-based source FIFOs, consumer, and a round-robin word-order reference model.
// Follows FIFO_READ_MUX_BURST_EN to choose the expected burst length.
module tb_fifo_read_mux;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 16;
`ifdef FIFO_READ_MUX_BURST_EN
    localparam int unsigned BURST = MB;
`else
    localparam int unsigned BURST = 1;
`endif

    logic            BUS_CLK = 1'b0;
    logic            BUS_RST = 1'b1;
    logic [N-1:0]    SRC_EMPTY;
    logic [N*DW-1:0] SRC_DATA;
    logic [N-1:0]    SRC_READ;
    logic            FIFO_READ_NEXT;
    logic            FIFO_EMPTY;
    logic [DW-1:0]   FIFO_DATA;
    logic [N-1:0]    GRANT;
    logic            READ_ERROR;

    always #5 BUS_CLK = ~BUS_CLK;

    fifo_read_mux #(
        .N_SRC     (N),
        .DSIZE     (DW),
        .MAX_BURST (MB)
    ) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .SRC_EMPTY      (SRC_EMPTY),
        .SRC_DATA       (SRC_DATA),
        .SRC_READ       (SRC_READ),
        .FIFO_READ_NEXT (FIFO_READ_NEXT),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_DATA      (FIFO_DATA),
        .GRANT          (GRANT),
        .READ_ERROR     (READ_ERROR)
    );

    logic [DW-1:0] src_q [N][$];
    logic [DW-1:0] exp_q [$];
    int unsigned   exp_grants [$];
    int unsigned   exp_gwords [$];

    int n_assert = 0;
    int n_fail   = 0;
    int delivered = 0;

    logic [N-1:0]  obs_rd, obs_gr, cur_gr;
    logic          obs_fe, obs_re;
    logic [DW-1:0] obs_fd;

    bit in_ep;
    int ep_n, ep_words, gap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return N;
    endfunction

    function automatic bit srcs_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: rounds of round-robin service, each grant taking min(remaining, BURST) words
    task automatic build_expected(input int unsigned start_last);
        int unsigned cnt [N];
        int unsigned pos [N];
        int unsigned total = 0;
        int unsigned last = start_last;
        exp_q.delete();
        exp_grants.delete();
        exp_gwords.delete();
        for (int i = 0; i < N; i++) begin
            cnt[i] = src_q[i].size();
            pos[i] = 0;
            total += cnt[i];
        end
        while (total > 0) begin
            for (int unsigned k = 1; k <= N; k++) begin
                int unsigned s = (last + k) % N;
                if (cnt[s] > 0) begin
                    int unsigned take = (cnt[s] < BURST) ? cnt[s] : BURST;
                    for (int unsigned j = 0; j < take; j++) exp_q.push_back(src_q[s][pos[s] + j]);
                    pos[s] += take;
                    cnt[s] -= take;
                    total  -= take;
                    exp_grants.push_back(s);
                    exp_gwords.push_back(take);
                    last = s;
                    break;
                end
            end
        end
        in_ep = 1'b0;
        ep_n = 0;
        ep_words = 0;
        gap = 0;
    endtask

    task automatic drive_srcs();
        for (int i = 0; i < N; i++) begin
            SRC_EMPTY[i] = (src_q[i].size() == 0);
            SRC_DATA[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic cycle(input logic rn);
        logic [DW-1:0] e;
        FIFO_READ_NEXT = rn;
        drive_srcs();
        @(negedge BUS_CLK);
        obs_rd = SRC_READ;
        obs_gr = GRANT;
        obs_fe = FIFO_EMPTY;
        obs_fd = FIFO_DATA;
        obs_re = READ_ERROR;
        check("grant_onehot", 64'($countones(obs_gr) <= 1), 64'h1);
        check("read_outside_grant", 64'(obs_rd & ~obs_gr), 64'h0);
        check("read_from_empty", 64'(obs_rd & SRC_EMPTY), 64'h0);
        if (rn && !obs_fe) begin
            delivered++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data", 64'(obs_fd), 64'(e));
            end else begin
                check("extra_word", 64'(exp_q.size()), 64'h1);
            end
        end
        if (obs_gr != '0) begin
            if (!in_ep) begin
                in_ep = 1'b1;
                ep_words = 0;
                cur_gr = obs_gr;
                if (ep_n < exp_grants.size())
                    check("grant_order", 64'(oh_idx(obs_gr)), 64'(exp_grants[ep_n]));
                else
                    check("extra_grant", 64'(ep_n), 64'(exp_grants.size()));
                if (ep_n > 0) check("idle_bubble", 64'(gap), 64'h1);
            end else begin
                check("grant_stable", 64'(obs_gr), 64'(cur_gr));
            end
            if (obs_rd != '0) ep_words++;
            gap = 0;
        end else begin
            if (in_ep) begin
                if (ep_n < exp_gwords.size())
                    check("burst_len", 64'(ep_words), 64'(exp_gwords[ep_n]));
                ep_n++;
                in_ep = 1'b0;
                gap = 0;
            end
            gap++;
        end
        @(posedge BUS_CLK);
        #1;
        for (int i = 0; i < N; i++)
            if (obs_rd[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    endtask

    task automatic drain(input int max_cyc, input int unsigned stall_pct);
        int c = 0;
        while (!(exp_q.size() == 0 && srcs_empty() && obs_fe === 1'b1 && obs_gr == '0) && c < max_cyc) begin
            cycle($urandom_range(99) >= stall_pct);
            c++;
        end
        check("drain_in_time", 64'(c < max_cyc), 64'h1);
        check("grant_count", 64'(ep_n), 64'(exp_grants.size()));
        check("words_left", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic rst_on();
        BUS_RST = 1'b1;
        FIFO_READ_NEXT = 1'b0;
        @(negedge BUS_CLK);
        check("rst_fifo_empty", 64'(FIFO_EMPTY), 64'h1);
        check("rst_fifo_data", 64'(FIFO_DATA), 64'h0);
        check("rst_src_read", 64'(SRC_READ), 64'h0);
        check("rst_grant", 64'(GRANT), 64'h0);
        check("rst_read_error", 64'(READ_ERROR), 64'h0);
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic rst_off();
        obs_fe = 1'b1;
        obs_gr = '0;
        BUS_RST = 1'b0;
    endtask

    initial begin
        int d0;
        logic [DW-1:0] w0;
        int reads;

        FIFO_READ_NEXT = 1'b0;
        drive_srcs();
        build_expected(N - 1);
        rst_on();
        rst_off();

        // All sources empty: nothing granted, then one error pulse for a pop of nothing
        repeat (20) begin
            cycle(1'b0);
            check("idle_fifo_empty", 64'(obs_fe), 64'h1);
            check("idle_src_read", 64'(obs_rd), 64'h0);
            check("idle_grant", 64'(obs_gr), 64'h0);
            check("idle_read_error", 64'(obs_re), 64'h0);
        end
        cycle(1'b1);
        check("rderr_before", 64'(obs_re), 64'h0);
        cycle(1'b0);
        check("rderr_pulse", 64'(obs_re), 64'h1);
        cycle(1'b0);
        check("rderr_single", 64'(obs_re), 64'h0);

        // Source 2 holds 1..5: first word visible in the third cycle after release
        rst_on();
        for (int j = 1; j <= 5; j++) src_q[2].push_back(DW'(j));
        build_expected(N - 1);
        rst_off();
        cycle(1'b1);
        check("lat_c1_empty", 64'(obs_fe), 64'h1);
        check("lat_c1_grant", 64'(obs_gr), 64'h0);
        cycle(1'b1);
        check("lat_c2_empty", 64'(obs_fe), 64'h1);
        check("lat_c2_grant", 64'(obs_gr), 64'h4);
        check("lat_c2_read", 64'(obs_rd), 64'h4);
        cycle(1'b1);
        check("lat_c3_empty", 64'(obs_fe), 64'h0);
        check("lat_c3_data", 64'(obs_fd), 64'h1);
        drain(200, 0);

        // Five sources with 40 words each, consumer always popping
        rst_on();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 40; j++) src_q[i].push_back($urandom);
        build_expected(N - 1);
        rst_off();
        d0 = delivered;
        drain(2000, 0);
        check("words_total", 64'(delivered - d0), 64'd200);

        // Consumer stalled for 30 cycles with source 1 loaded
        rst_on();
        for (int j = 0; j < 6; j++) src_q[1].push_back($urandom);
        w0 = src_q[1][0];
        build_expected(N - 1);
        rst_off();
        reads = 0;
        repeat (30) begin
            cycle(1'b0);
            if (obs_rd != '0) reads++;
            if (!obs_fe) check("stall_data_stable", 64'(obs_fd), 64'(w0));
        end
        check("stall_reads", 64'(reads), 64'h1);
        check("stall_full", 64'(obs_fe), 64'h0);
        drain(300, 0);

        // Random fill levels and random consumer stalls
        repeat (3) begin
            rst_on();
            for (int i = 0; i < N; i++) begin
                int unsigned cnt = $urandom_range(20);
                for (int unsigned j = 0; j < cnt; j++) src_q[i].push_back($urandom);
            end
            build_expected(N - 1);
            rst_off();
            drain(3000, 30);
        end

        // Reset in the middle of serving source 3; source 0 must win afterwards
        rst_on();
        for (int j = 0; j < 20; j++) src_q[3].push_back($urandom);
        build_expected(N - 1);
        rst_off();
        repeat (6) cycle(1'b1);
        #2 BUS_RST = 1'b1;
        #1;
        check("midrst_fifo_empty", 64'(FIFO_EMPTY), 64'h1);
        check("midrst_fifo_data", 64'(FIFO_DATA), 64'h0);
        check("midrst_src_read", 64'(SRC_READ), 64'h0);
        check("midrst_grant", 64'(GRANT), 64'h0);
        check("midrst_read_error", 64'(READ_ERROR), 64'h0);
        for (int j = 0; j < 4; j++) src_q[0].push_back($urandom);
        drive_srcs();
        rst_on();
        build_expected(N - 1);
        rst_off();
        drain(500, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
